// File: rtl/instr_encoder_if.sv
// Handshake and memory-write bus for the RV32I instruction encoder.
// The slave modport is the encoder's view; master is the producer/observer.
interface instr_encoder_if;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        err;
  logic [1:0]  err_code;
  logic [7:0]  err_count;
  logic        done;

  modport slave (
    input  start, base_addr, in_valid, in_last, fmt, opcode, rd, rs1, rs2,
           funct3, funct7, imm,
    output in_ready, mem_wen, mem_addr, mem_wdata, err, err_code, err_count, done
  );

  modport master (
    output start, base_addr, in_valid, in_last, fmt, opcode, rd, rs1, rs2,
           funct3, funct7, imm,
    input  in_ready, mem_wen, mem_addr, mem_wdata, err, err_code, err_count, done
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: accepts decoded instruction fields during a
// session, packs them into 32-bit words and writes them to consecutive
// addresses. Fields that fail format, alignment or range checks are rejected
// with a one-cycle error pulse and a saturating error counter.
module instr_encoder (
  input  logic            clk,
  input  logic            rst,
  instr_encoder_if.slave  bus
);

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_U = 3'b011;
  localparam logic [2:0] FMT_J = 3'b100;
  localparam logic [2:0] FMT_R = 3'b101;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;
  localparam logic [1:0] ERR_FMT   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_FLUSH = 2'b10
  } state_t;

  state_t      r_state;
  logic [31:0] r_ptr;
  logic        r_in_ready;
  logic        r_mem_wen;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_err;
  logic [1:0]  r_err_code;
  logic [7:0]  r_err_count;
  logic        r_done;

  logic [31:0] w_word;
  logic [1:0]  w_code;
  logic [31:0] w_imm;

  assign w_imm = bus.imm;

  // Pack the current fields and classify them; only the fields a format uses
  // reach w_word, so unused inputs can never leak into a written word.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_word = '0;
    w_code = ERR_NONE;
    case (bus.fmt)
      FMT_R: w_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
      FMT_I: begin
        w_word = {w_imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        if (w_imm[31:11] != {21{w_imm[11]}}) w_code = ERR_RANGE;
      end
      FMT_S: begin
        w_word = {w_imm[11:5], bus.rs2, bus.rs1, bus.funct3, w_imm[4:0], bus.opcode};
        if (w_imm[31:11] != {21{w_imm[11]}}) w_code = ERR_RANGE;
      end
      FMT_B: begin
        w_word = {w_imm[12], w_imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                  w_imm[4:1], w_imm[11], bus.opcode};
        if (w_imm[0])                                  w_code = ERR_ALIGN;
        else if (w_imm[31:12] != {20{w_imm[12]}})      w_code = ERR_RANGE;
      end
      FMT_U: begin
        w_word = {w_imm[31:12], bus.rd, bus.opcode};
        if (w_imm[11:0] != 12'd0) w_code = ERR_RANGE;
      end
      FMT_J: begin
        w_word = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.rd, bus.opcode};
        if (w_imm[0])                                  w_code = ERR_ALIGN;
        else if (w_imm[31:20] != {12{w_imm[20]}})      w_code = ERR_RANGE;
      end
      default: w_code = ERR_FMT;
    endcase
  end

  // Session FSM with registered handshake, write and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_in_ready  <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_err_count <= '0;
      r_done      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_mem_wen  <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_RUN;
            r_ptr      <= bus.base_addr;
            r_in_ready <= 1'b1;
          end
        end
        S_RUN: begin
          if (bus.in_valid && r_in_ready) begin
            if (w_code != ERR_NONE) begin
              r_err      <= 1'b1;
              r_err_code <= w_code;
              if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            end else begin
              r_mem_wen   <= 1'b1;
              r_mem_addr  <= r_ptr;
              r_mem_wdata <= w_word;
              r_ptr       <= r_ptr + 32'd4;
            end
            if (bus.in_last) begin
              r_state    <= S_FLUSH;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.mem_wen   = r_mem_wen;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.err       = r_err;
  assign bus.err_code  = r_err_code;
  assign bus.err_count = r_err_count;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed sessions plus randomized
// traffic compared cycle by cycle against an arithmetic reference model.
module tb_instr_encoder;

  logic clk;
  logic rst;
  instr_encoder_if bus ();

  instr_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int unsigned m_phase;   // 0 idle, 1 accepting, 2 ending session
  logic [31:0] m_ptr;
  int unsigned m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Word value and error code computed from the instruction-set rules using
  // field arithmetic and signed integer ranges.
  function automatic void model_encode(
    input  logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
    input  logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
    input  logic [6:0] f7, input logic [31:0] imm,
    output logic [31:0] word, output logic [1:0] code);
    int signed   simm;
    bit          ok;
    bit [31:0]   u_op, u_rd, u_rs1, u_rs2, u_f3, u_f7, u_imm;
    simm  = $signed(imm);
    u_op  = 32'(op);  u_rd = 32'(rd);  u_rs1 = 32'(rs1);  u_rs2 = 32'(rs2);
    u_f3  = 32'(f3);  u_f7 = 32'(f7);  u_imm = imm;
    word  = 32'd0;
    ok    = 1'b1;
    case (f)
      3'd0: begin
        word = u_op + (u_rd << 7) + (u_f3 << 12) + (u_rs1 << 15) + ((u_imm & 32'hFFF) << 20);
        ok = (simm >= -2048) && (simm <= 2047);
      end
      3'd1: begin
        word = u_op + ((u_imm & 32'h1F) << 7) + (u_f3 << 12) + (u_rs1 << 15) + (u_rs2 << 20)
             + (((u_imm >> 5) & 32'h7F) << 25);
        ok = (simm >= -2048) && (simm <= 2047);
      end
      3'd2: begin
        word = u_op + (((u_imm >> 11) & 32'h1) << 7) + (((u_imm >> 1) & 32'hF) << 8)
             + (u_f3 << 12) + (u_rs1 << 15) + (u_rs2 << 20)
             + (((u_imm >> 5) & 32'h3F) << 25) + (((u_imm >> 12) & 32'h1) << 31);
        ok = (simm >= -4096) && (simm <= 4095);
      end
      3'd3: begin
        word = u_op + (u_rd << 7) + (u_imm & 32'hFFFFF000);
        ok = (u_imm % 4096) == 0;
      end
      3'd4: begin
        word = u_op + (u_rd << 7) + (((u_imm >> 12) & 32'hFF) << 12)
             + (((u_imm >> 11) & 32'h1) << 20) + (((u_imm >> 1) & 32'h3FF) << 21)
             + (((u_imm >> 20) & 32'h1) << 31);
        ok = (simm >= -(1 << 20)) && (simm <= (1 << 20) - 1);
      end
      3'd5: word = u_op + (u_rd << 7) + (u_f3 << 12) + (u_rs1 << 15) + (u_rs2 << 20) + (u_f7 << 25);
      default: ok = 1'b1;
    endcase
    if (f > 3'd5)                                  code = 2'b11;
    else if ((f == 3'd2 || f == 3'd4) && imm[0])   code = 2'b10;
    else if (!ok)                                  code = 2'b01;
    else                                           code = 2'b00;
  endfunction

  // One clock cycle: predict from the inputs currently driven, clock, compare.
  task automatic step();
    logic [31:0] e_word, e_addr;
    logic [1:0]  e_code, c;
    bit          e_wen, e_err, e_done;
    e_wen = 0; e_err = 0; e_done = 0; e_code = 2'b00; e_word = '0; e_addr = '0;
    check("in_ready", 32'(bus.in_ready), 32'(m_phase == 1));
    case (m_phase)
      0: if (bus.start) begin m_phase = 1; m_ptr = bus.base_addr; end
      1: if (bus.in_valid) begin
           model_encode(bus.fmt, bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.funct3,
                        bus.funct7, bus.imm, e_word, c);
           if (c != 2'b00) begin
             e_err = 1; e_code = c;
             if (m_cnt < 255) m_cnt++;
           end else begin
             e_wen = 1; e_addr = m_ptr; m_ptr = m_ptr + 32'd4;
           end
           if (bus.in_last) m_phase = 2;
         end
      default: begin e_done = 1; m_phase = 0; end
    endcase
    @(posedge clk);
    #1;
    check("mem_wen", 32'(bus.mem_wen), 32'(e_wen));
    check("err", 32'(bus.err), 32'(e_err));
    check("done", 32'(bus.done), 32'(e_done));
    check("err_count", 32'(bus.err_count), m_cnt);
    if (e_wen) begin
      check("mem_addr", bus.mem_addr, e_addr);
      check("mem_wdata", bus.mem_wdata, e_word);
    end
    if (e_err) check("err_code", 32'(bus.err_code), 32'(e_code));
  endtask

  task automatic quiet();
    bus.start = 0; bus.in_valid = 0; bus.in_last = 0;
  endtask

  task automatic begin_session(input logic [31:0] base);
    quiet();
    bus.start = 1; bus.base_addr = base;
    step();
    bus.start = 0;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, input bit last);
    bus.in_valid = 1; bus.in_last = last; bus.fmt = f; bus.opcode = op; bus.rd = rd;
    bus.rs1 = rs1; bus.rs2 = rs2; bus.funct3 = f3; bus.funct7 = f7; bus.imm = imm;
    step();
    quiet();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".in_ready"},  32'(bus.in_ready), 0);
    check({tag, ".mem_wen"},   32'(bus.mem_wen), 0);
    check({tag, ".mem_addr"},  bus.mem_addr, 0);
    check({tag, ".mem_wdata"}, bus.mem_wdata, 0);
    check({tag, ".err"},       32'(bus.err), 0);
    check({tag, ".err_code"},  32'(bus.err_code), 0);
    check({tag, ".err_count"}, 32'(bus.err_count), 0);
    check({tag, ".done"},      32'(bus.done), 0);
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = '0; m_cnt = 0;
  endtask

  int bnd [12] = '{2047, 2048, -2048, -2049, 4095, 4096, -4096, -4097,
                   1048575, 1048576, -1048576, -1048577};

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 5))
      0:       return 32'($signed($urandom_range(0, 64)) - 32);
      1:       return 32'(bnd[$urandom_range(0, 11)]);
      2:       return 32'($urandom);
      3:       return 32'($urandom) & 32'hFFFFF000;
      4:       return 32'($urandom_range(0, 30)) * 2;
      default: return 32'($signed($urandom_range(0, 2000)) - 1000) * 2;
    endcase
  endfunction

  initial begin
    rst = 1; quiet();
    bus.base_addr = '0; bus.fmt = '0; bus.opcode = '0; bus.rd = '0; bus.rs1 = '0;
    bus.rs2 = '0; bus.funct3 = '0; bus.funct7 = '0; bus.imm = '0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(posedge clk); #1; rst = 0;
    step();

    // Single I-type word.
    begin_session(32'h100);
    send(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1);
    check("i_word", bus.mem_wdata, 32'h00500093);
    check("i_addr", bus.mem_addr, 32'h100);
    step(); step();

    // S then B (last).
    begin_session(32'h100);
    send(3'd1, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 0);
    check("s_word", bus.mem_wdata, 32'h0020A423);
    send(3'd2, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4, 1);
    check("b_word", bus.mem_wdata, 32'hFE000EE3);
    check("b_addr", bus.mem_addr, 32'h104);
    step(); step();

    // U and J.
    begin_session(32'h200);
    send(3'd3, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 0);
    check("u_word", bus.mem_wdata, 32'h123452B7);
    send(3'd4, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1);
    check("j_word", bus.mem_wdata, 32'h008000EF);
    step(); step();

    // Rejections, last one ends the session.
    begin_session(32'h300);
    send(3'd2, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 0);
    check("align_code", 32'(bus.err_code), 32'h2);
    send(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 0);
    check("range_code", 32'(bus.err_code), 32'h1);
    send(3'd7, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1);
    check("fmt_code", 32'(bus.err_code), 32'h3);
    check("err_count3", 32'(bus.err_count), 32'd3);
    step();
    send(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 0);  // valid in IDLE: ignored
    step();
    // Pointer must still be 0x300 after the rejected words.
    begin_session(32'h300);
    send(3'd0, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1);
    step(); step();

    // Address wrap, with in_valid held in IDLE beforehand.
    bus.in_valid = 1; bus.fmt = 3'd5;
    step(); step();
    quiet();
    begin_session(32'hFFFFFFFC);
    send(3'd5, 7'b0110011, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'd0, 0);
    check("wrap_addr0", bus.mem_addr, 32'hFFFFFFFC);
    send(3'd5, 7'b0110011, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'd0, 1);
    check("wrap_addr1", bus.mem_addr, 32'h0);
    step(); step();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      bus.start     = ($urandom_range(0, 3) == 0);
      bus.base_addr = $urandom & 32'hFFFFFFFC;
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_last   = ($urandom_range(0, 7) == 0);
      bus.fmt       = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1))
                                                  : 3'($urandom_range(0, 5));
      bus.opcode    = 7'($urandom);
      bus.rd        = 5'($urandom);
      bus.rs1       = 5'($urandom);
      bus.rs2       = 5'($urandom);
      bus.funct3    = 3'($urandom);
      bus.funct7    = 7'($urandom);
      bus.imm       = rand_imm();
      step();
    end
    quiet();
    step(); step();

    // Error counter saturation.
    begin_session(32'h0);
    for (int i = 0; i < 260; i++)
      send(3'd6, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 0);
    check("err_sat", 32'(bus.err_count), 32'd255);

    // Reset right after a transfer discards the pending write.
    send(3'd5, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 0);
    bus.in_valid = 1; bus.fmt = 3'd5;
    @(posedge clk); #1;
    rst = 1; #1;
    check_all_zero("mid_rst");
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    check_all_zero("post_rst");
    for (int i = 0; i < 4; i++) step();
    quiet();
    begin_session(32'h40);
    send(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 1);
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
